// File: rtl/bcd_7seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_7seg_scan_driver
//  Description : Time-multiplexed multi-digit BCD to 7-segment driver.
//                A valid/ready port fills a shadow buffer that is committed to
//                the displayed buffer only at frame boundaries, so the display
//                never tears. Each digit slot opens with a short dead-time
//                during which all digits are off, to suppress ghosting.
//                Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading
//                zero digits (digit 0 is always shown).
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_7seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_bcd,
    input  logic [NUM_DIGITS-1:0]     load_dp,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     dig_sel
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      C_CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            C_SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  C_DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] C_DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_active_bcd;
    logic [NUM_DIGITS-1:0]   r_active_dp;

    logic                    w_frame_end;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_lz_sel;
    logic [NUM_DIGITS-1:0]   w_dig_hot;
    logic [6:0]              w_seg_raw;

    assign load_ready  = ~r_pending;
    assign w_frame_end = en && (r_cnt == C_CNT_LAST) && (r_idx == C_IDX_LAST);

    // Slot counter and digit index; both freeze while scanning is disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (en) begin
            if (r_cnt == C_CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // One-deep shadow buffer; commits to the displayed buffer only on a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= 1'b0;
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
            r_active_bcd <= '1;
            r_active_dp  <= '0;
        end else if (load_valid && !r_pending) begin
            r_shadow_bcd <= load_bcd;
            r_shadow_dp  <= load_dp;
            r_pending    <= 1'b1;
        end else if (w_frame_end && r_pending) begin
            r_active_bcd <= r_shadow_bcd;
            r_active_dp  <= r_shadow_dp;
            r_pending    <= 1'b0;
        end
    end

    // Dead-time phase at the start of each slot (absent when BLANK_CYC is 0)
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CNT_W-1:0] C_BLANK = CNT_W'(BLANK_CYC);
            assign w_blank = (r_cnt < C_BLANK);
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic w_run;

    // Mark zero digits from the top down until the first non-zero digit; digit 0 never blanks
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (w_run && (r_active_bcd[i*4 +: 4] == 4'd0)) begin
                w_lz[i] = 1'b1;
            end else begin
                w_run = 1'b0;
            end
        end
    end
`else
    assign w_lz = '0;
`endif

    // Select the current digit's nibble/dp and decode it to active-high segments
    always_comb begin
        w_nib     = 4'hF;
        w_dp_sel  = 1'b0;
        w_lz_sel  = 1'b0;
        w_dig_hot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib        = r_active_bcd[i*4 +: 4];
                w_dp_sel     = r_active_dp[i];
                w_lz_sel     = w_lz[i];
                w_dig_hot[i] = 1'b1;
            end
        end
        case (w_nib)
            4'd0:    w_seg_raw = 7'b1111110;
            4'd1:    w_seg_raw = 7'b0110000;
            4'd2:    w_seg_raw = 7'b1101101;
            4'd3:    w_seg_raw = 7'b1111001;
            4'd4:    w_seg_raw = 7'b0110011;
            4'd5:    w_seg_raw = 7'b1011011;
            4'd6:    w_seg_raw = 7'b1011111;
            4'd7:    w_seg_raw = 7'b1110000;
            4'd8:    w_seg_raw = 7'b1111111;
            4'd9:    w_seg_raw = 7'b1111011;
            default: w_seg_raw = 7'b0000000;
        endcase
        if (w_lz_sel) begin
            w_seg_raw = 7'b0000000;
        end
    end

    // Registered pin drive with polarity applied last; idle during reset, disable and dead-time
    always_ff @(posedge clk) begin
        if (rst || !en || w_blank) begin
            seg     <= C_SEG_OFF;
            dp      <= C_DP_OFF;
            dig_sel <= C_DIG_OFF;
        end else begin
            seg     <= w_seg_raw ^ C_SEG_OFF;
            dp      <= w_dp_sel ^ C_DP_OFF;
            dig_sel <= w_dig_hot ^ C_DIG_OFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_7seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_7seg_scan_driver
//  Description : Self-checking bench for bcd_7seg_scan_driver (4 digits,
//                SCAN_DIV=8, BLANK_CYC=2). A second instance with both
//                polarities inverted shares the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_7seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load_valid;
    logic [15:0] load_bcd;
    logic [3:0]  load_dp;
    logic        load_ready,   load_ready_n;
    logic [6:0]  seg,          seg_n;
    logic        dp,           dp_n;
    logic [3:0]  dig_sel,      dig_sel_n;

    int checks   = 0;
    int failures = 0;

    bcd_7seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid),
        .load_ready(load_ready), .load_bcd(load_bcd), .load_dp(load_dp),
        .seg(seg), .dp(dp), .dig_sel(dig_sel)
    );

    bcd_7seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_n (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid),
        .load_ready(load_ready_n), .load_bcd(load_bcd), .load_dp(load_dp),
        .seg(seg_n), .dp(dp_n), .dig_sel(dig_sel_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dpv;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0: dec = 7'h7E;  4'd1: dec = 7'h30;  4'd2: dec = 7'h6D;
            4'd3: dec = 7'h79;  4'd4: dec = 7'h33;  4'd5: dec = 7'h5B;
            4'd6: dec = 7'h5F;  4'd7: dec = 7'h70;  4'd8: dec = 7'h7F;
            4'd9: dec = 7'h7B;  default: dec = 7'h00;
        endcase
    endfunction

    // Compare both instances against one active-high expectation
    task automatic chk_out(input string name, input logic [3:0] edig,
                           input logic [6:0] eseg, input logic edp, input bit cmp_seg);
        logic [3:0] ndig;
        logic [6:0] nseg;
        logic       ndp;
        ndig = ~edig;
        nseg = ~eseg;
        ndp  = ~edp;
        check({name, "_dig"},   {28'd0, dig_sel},   {28'd0, edig});
        check({name, "_dig_n"}, {28'd0, dig_sel_n}, {28'd0, ndig});
        if (cmp_seg) begin
            check({name, "_seg"},   {25'd0, seg},   {25'd0, eseg});
            check({name, "_seg_n"}, {25'd0, seg_n}, {25'd0, nseg});
            check({name, "_dp"},    {31'd0, dp},    {31'd0, edp});
            check({name, "_dp_n"},  {31'd0, dp_n},  {31'd0, ndp});
        end
    endtask

    task automatic wait_dig(input logic [3:0] want, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (dig_sel == want) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (load_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Check one full frame; entry is just after edge n0, outputs reflect counter state n0-1
    task automatic run_frame(input int n0, input logic [15:0] v, input string name);
        int         s, c, i;
        logic [3:0] edig;
        for (int n = n0; n < n0 + 32; n++) begin
            s    = n - 1;
            c    = s % 8;
            i    = (s / 8) % 4;
            edig = (c >= 2) ? 4'(1 << i) : 4'd0;
            chk_out(name, edig, dec(v[i*4 +: 4]), 1'b0, c >= 2);
            if (n != n0 + 31) tick();
        end
    endtask

    initial begin
        bit ok;
        int bad;

        vecs[0] = '{16'h1234, 4'b0000, {7'h30, 7'h6D, 7'h79, 7'h33}};
        vecs[1] = '{16'h5678, 4'b1001, {7'h5B, 7'h5F, 7'h70, 7'h7F}};
        vecs[2] = '{16'h9BA0, 4'b0100, {7'h7B, 7'h00, 7'h00, 7'h7E}};
        vecs[3] = '{16'hFEDC, 4'b1010, {7'h00, 7'h00, 7'h00, 7'h00}};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[4] = '{16'h0070, 4'b0001, {7'h00, 7'h00, 7'h70, 7'h7E}};
        vecs[5] = '{16'h0000, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h7E}};
`else
        vecs[4] = '{16'h0070, 4'b0001, {7'h7E, 7'h7E, 7'h70, 7'h7E}};
        vecs[5] = '{16'h0000, 4'b0000, {7'h7E, 7'h7E, 7'h7E, 7'h7E}};
`endif

        // Reset state
        rst = 1'b1; en = 1'b0; load_valid = 1'b0; load_bcd = '0; load_dp = '0;
        tick();
        tick();
        chk_out("reset", 4'd0, 7'h00, 1'b0, 1'b1);
        check("reset_ready", {31'd0, load_ready}, 32'd1);

        // Load right after reset, second load held while pending
        rst = 1'b0; en = 1'b1; load_valid = 1'b1; load_bcd = 16'h1234; load_dp = 4'b0000;
        tick();                                   // edge 1: accept 0x1234
        check("accept1_ready", {31'd0, load_ready}, 32'd0);
        load_bcd = 16'h5678;
        bad = 0;
        for (int n = 2; n <= 31; n++) begin
            tick();
            if (load_ready !== 1'b0) bad++;
        end
        check("pending_ready_low", bad, 0);
        tick();                                   // edge 32: commit
        check("commit_ready", {31'd0, load_ready}, 32'd1);
        tick();                                   // edge 33: accept 0x5678
        check("accept2_ready", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
        run_frame(33, 16'h1234, "frame_1234");
        check("commit2_ready", {31'd0, load_ready}, 32'd1);
        tick();
        run_frame(65, 16'h5678, "frame_5678");

        // Table of load values, each checked across one committed frame
        for (int v = 0; v < 6; v++) begin
            wait_ready(ok);
            check("tbl_ready_timeout", {31'd0, ok}, 32'd1);
            load_valid = 1'b1; load_bcd = vecs[v].bcd; load_dp = vecs[v].dpv;
            tick();
            load_valid = 1'b0;
            wait_ready(ok);
            check("tbl_commit_timeout", {31'd0, ok}, 32'd1);
            for (int d = 0; d < 4; d++) begin
                wait_dig(4'(1 << d), ok);
                check("tbl_dig_timeout", {31'd0, ok}, 32'd1);
                chk_out($sformatf("tbl%0d_d%0d", v, d), 4'(1 << d),
                        vecs[v].segs[d*7 +: 7], vecs[v].dpv[d], 1'b1);
            end
        end

        // Scan freeze at cnt=5 of digit 1, then resume
        wait_dig(4'b0001, ok);
        check("frz_wait0", {31'd0, ok}, 32'd1);
        wait_dig(4'b0010, ok);                    // counter state now cnt=3 of digit 1
        check("frz_wait1", {31'd0, ok}, 32'd1);
        tick();
        tick();                                   // counter state now cnt=5
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_out($sformatf("frozen%0d", k), 4'd0, 7'h00, 1'b0, 1'b1);
        end
        en = 1'b1;
        tick(); chk_out("resume1", 4'b0010, 7'h00, 1'b0, 1'b0);
        tick(); chk_out("resume2", 4'b0010, 7'h00, 1'b0, 1'b0);
        tick(); chk_out("resume3", 4'b0010, 7'h00, 1'b0, 1'b0);
        tick(); chk_out("resume4", 4'b0000, 7'h00, 1'b0, 1'b0);
        tick(); chk_out("resume5", 4'b0000, 7'h00, 1'b0, 1'b0);
        tick(); chk_out("resume6", 4'b0100, 7'h00, 1'b0, 1'b0);

        // Reset with a load pending: load dropped, display blank, scan restarts at digit 0
        wait_ready(ok);
        check("rst_ready_timeout", {31'd0, ok}, 32'd1);
        load_valid = 1'b1; load_bcd = 16'h1111; load_dp = 4'hF;
        tick();
        load_valid = 1'b0;
        check("rst_pending", {31'd0, load_ready}, 32'd0);
        rst = 1'b1;
        tick();
        check("midrst_ready", {31'd0, load_ready}, 32'd1);
        chk_out("midrst", 4'd0, 7'h00, 1'b0, 1'b1);
        rst = 1'b0;
        tick();
        tick();
        chk_out("restart_blank", 4'd0, 7'h00, 1'b0, 1'b0);
        tick();
        chk_out("restart_d0", 4'b0001, 7'h00, 1'b0, 1'b1);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (load_ready !== 1'b1) bad++;
            if (dig_sel != 4'd0 && (seg != 7'h00 || dp != 1'b0)) bad++;
        end
        check("after_rst_stays_blank", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
